bp_be_accel_store_engine: RTL and testbench

//  Multi-channel writeback engine behind the BE accelerator pipe. Buffers result blocks,

---
 rtl/bp_be_accel_store_engine_pkg.sv | 28 ++
 rtl/bp_be_accel_store_engine_fifo.sv | 48 ++++
 rtl/bp_be_accel_store_engine.sv | 199 +++++++++++++++++++
 tb/tb_bp_be_accel_store_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_accel_store_engine_pkg.sv
// Shared types for the BE accelerator store engine: FSM states, CSR indices, channel window.
// Optional BP_ACCEL_STORE_PERF_EN adds performance counters in the engine itself.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_send,
    e_fence
  } bp_be_accel_store_state_e;

  localparam logic [1:0] csr_base_lp   = 2'd0;
  localparam logic [1:0] csr_limit_lp  = 2'd1;
  localparam logic [1:0] csr_stride_lp = 2'd2;
  localparam logic [1:0] csr_ptr_lp    = 2'd3;

  localparam logic [3:0] csr_perf_beats_lp  = 4'd12;
  localparam logic [3:0] csr_perf_stall_lp  = 4'd13;
  localparam logic [3:0] csr_perf_nocred_lp = 4'd14;
  localparam logic [3:0] csr_status_lp      = 4'd15;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] limit;
    logic [63:0] stride;
    logic [63:0] ptr;
  } bp_be_accel_store_win_s;

endpackage

// File: rtl/bp_be_accel_store_engine_fifo.sv
// Small 1-read/1-write circular FIFO; output is read combinationally from storage.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_and_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr, r_rptr;
  logic [cnt_w_lp-1:0] r_count;
  logic                w_push, w_pop;

  assign ready_and_o = (r_count != cnt_full_lp);
  assign v_o         = (r_count != '0);
  assign data_o      = r_mem[r_rptr];
  assign w_push      = v_i & ready_and_o;
  assign w_pop       = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == ptr_last_lp) ? '0 : r_wptr + ptr_w_lp'(1);
      if (w_pop)  r_rptr <= (r_rptr == ptr_last_lp) ? '0 : r_rptr + ptr_w_lp'(1);
      r_count <= r_count + cnt_w_lp'(w_push) - cnt_w_lp'(w_pop);
    end
  end

endmodule

// File: rtl/bp_be_accel_store_engine.sv
// Multi-channel store engine: slices buffered blocks into beats written to circular windows,
// with credit tracking and fence. Define BP_ACCEL_STORE_PERF_EN for perf counters at CSR 12-14.
module bp_be_accel_store_engine
  import bp_be_pkg::*;
#(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned data_width_p  = 128,
  parameter int unsigned block_width_p = 512,
  parameter int unsigned num_ch_p      = 2,
  parameter int unsigned fifo_els_p    = 2,
  parameter int unsigned credits_p     = 8,
  localparam int unsigned ch_w_lp      = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     csr_w_v_i,
  input  logic [3:0]               csr_addr_i,
  input  logic [63:0]              csr_data_i,
  output logic [63:0]              csr_data_o,
  input  logic                     blk_v_i,
  input  logic [ch_w_lp-1:0]       blk_ch_i,
  input  logic [block_width_p-1:0] blk_data_i,
  output logic                     blk_ready_and_o,
  output logic [paddr_width_p-1:0] wr_addr_o,
  output logic [data_width_p-1:0]  wr_data_o,
  output logic                     wr_v_o,
  input  logic                     wr_ready_and_i,
  input  logic                     wr_ack_v_i,
  input  logic                     fence_v_i,
  output logic                     fence_done_o,
  output logic                     busy_o,
  output logic                     panic_o
);

  localparam int unsigned beats_lp  = block_width_p / data_width_p;
  localparam int unsigned beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int unsigned cred_w_lp = $clog2(credits_p + 1);
  localparam logic [beat_w_lp-1:0] beat_last_lp = beat_w_lp'(beats_lp - 1);
  localparam logic [cred_w_lp-1:0] cred_max_lp  = cred_w_lp'(credits_p);
  localparam logic [63:0] addr_mask_lp =
    (paddr_width_p >= 64) ? '1 : ((64'd1 << paddr_width_p) - 64'd1);

  bp_be_accel_store_state_e r_state, w_state_nxt;
  bp_be_accel_store_win_s   r_win [num_ch_p];
  logic [beat_w_lp-1:0]     r_beat;
  logic [cred_w_lp-1:0]     r_credits;
  logic                     r_panic, r_fence_pend, r_held;

  logic                     w_fifo_v, w_fifo_yumi;
  logic [block_width_p+ch_w_lp-1:0] w_fifo_data;
  logic [block_width_p-1:0] w_blk;
  logic [ch_w_lp-1:0]       w_ch;
  logic                     w_start_ok, w_want, w_credit_ok, w_hs, w_last, w_fence_done;
  logic [63:0]              w_ptr_sum, w_ptr_nxt;
  logic [1:0]               w_csr_ch, w_csr_fld;
  logic                     w_csr_map;

  bsg_fifo_1r1w_small #(
    .width_p(block_width_p + ch_w_lp),
    .els_p  (fifo_els_p)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (blk_v_i),
    .ready_and_o(blk_ready_and_o),
    .data_i     ({blk_ch_i, blk_data_i}),
    .v_o        (w_fifo_v),
    .data_o     (w_fifo_data),
    .yumi_i     (w_fifo_yumi)
  );

  assign {w_ch, w_blk} = w_fifo_data;

  // A pending fence only holds back the start of a new block; a block already begun
  // (or a beat already presented) runs to completion so wr_v_o never drops mid-offer.
  assign w_start_ok  = ~r_fence_pend | (r_beat != '0) | r_held;
  assign w_want      = (r_state != e_fence) & w_fifo_v & w_start_ok;
  assign w_credit_ok = (r_credits < cred_max_lp);
  assign wr_v_o      = w_want & w_credit_ok;
  assign w_hs        = wr_v_o & wr_ready_and_i;
  assign w_last      = (r_beat == beat_last_lp);
  assign w_fifo_yumi = w_hs & w_last;
  assign wr_addr_o   = wr_v_o ? r_win[w_ch].ptr[paddr_width_p-1:0] : '0;
  assign wr_data_o   = wr_v_o ? w_blk[r_beat*data_width_p +: data_width_p] : '0;

  assign w_fence_done = (r_state == e_fence) & (r_credits == '0);
  assign fence_done_o = w_fence_done;
  assign busy_o       = w_fifo_v | wr_v_o | (r_credits != '0);
  assign panic_o      = r_panic;

  assign w_ptr_sum = (r_win[w_ch].ptr + r_win[w_ch].stride) & addr_mask_lp;
  assign w_ptr_nxt = (w_ptr_sum >= r_win[w_ch].limit) ? r_win[w_ch].base : w_ptr_sum;

  assign w_csr_ch  = csr_addr_i[3:2];
  assign w_csr_fld = csr_addr_i[1:0];
  assign w_csr_map = (csr_addr_i < csr_perf_beats_lp) && (32'(w_csr_ch) < num_ch_p);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      e_idle: begin
        if (r_fence_pend)          w_state_nxt = e_fence;
        else if (w_hs & w_last)    w_state_nxt = fence_v_i ? e_idle : e_send;
        else if (w_fifo_v)         w_state_nxt = e_send;
      end
      e_send: begin
        if (w_hs & w_last)                   w_state_nxt = (r_fence_pend | fence_v_i) ? e_idle : e_send;
        else if (~w_fifo_v | ~w_start_ok)    w_state_nxt = e_idle;
      end
      e_fence: if (r_credits == '0) w_state_nxt = e_idle;
      default: w_state_nxt = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= e_idle;
      r_beat       <= '0;
      r_credits    <= '0;
      r_panic      <= 1'b0;
      r_fence_pend <= 1'b0;
      r_held       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_held       <= wr_v_o & ~wr_ready_and_i;
      r_fence_pend <= w_fence_done ? 1'b0 : (r_fence_pend | fence_v_i);
      if (w_hs) r_beat <= w_last ? '0 : r_beat + beat_w_lp'(1);
      if (w_hs & ~wr_ack_v_i)       r_credits <= r_credits + cred_w_lp'(1);
      else if (~w_hs & wr_ack_v_i) begin
        if (r_credits != '0) r_credits <= r_credits - cred_w_lp'(1);
        else                 r_panic   <= 1'b1;
      end
    end
  end

  // CSR writes are applied after the beat increment so they take priority on ptr.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned c = 0; c < num_ch_p; c++) r_win[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < num_ch_p; c++) begin
        if (w_hs && (32'(w_ch) == c)) r_win[c].ptr <= w_ptr_nxt;
        if (csr_w_v_i && w_csr_map && (32'(w_csr_ch) == c)) begin
          unique case (w_csr_fld)
            csr_base_lp: begin
              r_win[c].base <= csr_data_i & addr_mask_lp;
              r_win[c].ptr  <= csr_data_i & addr_mask_lp;
            end
            csr_limit_lp:  r_win[c].limit  <= csr_data_i & addr_mask_lp;
            csr_stride_lp: r_win[c].stride <= csr_data_i & addr_mask_lp;
            default:       r_win[c].ptr    <= csr_data_i & addr_mask_lp;
          endcase
        end
      end
    end
  end

`ifdef BP_ACCEL_STORE_PERF_EN
  logic [31:0] r_perf_beats, r_perf_stall, r_perf_nocred;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_perf_beats  <= '0;
      r_perf_stall  <= '0;
      r_perf_nocred <= '0;
    end else begin
      if (csr_w_v_i && csr_addr_i == csr_perf_beats_lp) r_perf_beats <= '0;
      else if (w_hs && r_perf_beats != '1)              r_perf_beats <= r_perf_beats + 32'd1;
      if (csr_w_v_i && csr_addr_i == csr_perf_stall_lp)          r_perf_stall <= '0;
      else if (wr_v_o && !wr_ready_and_i && r_perf_stall != '1)  r_perf_stall <= r_perf_stall + 32'd1;
      if (csr_w_v_i && csr_addr_i == csr_perf_nocred_lp)         r_perf_nocred <= '0;
      else if (w_want && !w_credit_ok && r_perf_nocred != '1)    r_perf_nocred <= r_perf_nocred + 32'd1;
    end
  end
`endif

  always_comb begin
    csr_data_o = '0;
    if (csr_addr_i == csr_status_lp) begin
      csr_data_o = 64'({r_panic, r_credits});
`ifdef BP_ACCEL_STORE_PERF_EN
    end else if (csr_addr_i == csr_perf_beats_lp) begin
      csr_data_o = 64'(r_perf_beats);
    end else if (csr_addr_i == csr_perf_stall_lp) begin
      csr_data_o = 64'(r_perf_stall);
    end else if (csr_addr_i == csr_perf_nocred_lp) begin
      csr_data_o = 64'(r_perf_nocred);
`endif
    end else if (w_csr_map) begin
      unique case (w_csr_fld)
        csr_base_lp:   csr_data_o = r_win[w_csr_ch[ch_w_lp-1:0]].base;
        csr_limit_lp:  csr_data_o = r_win[w_csr_ch[ch_w_lp-1:0]].limit;
        csr_stride_lp: csr_data_o = r_win[w_csr_ch[ch_w_lp-1:0]].stride;
        default:       csr_data_o = r_win[w_csr_ch[ch_w_lp-1:0]].ptr;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_be_accel_store_engine.sv
// Scoreboard bench for bp_be_accel_store_engine: directed blocks, credit, fence and panic cases.
module tb_bp_be_accel_store_engine;

  localparam int PW = 40, DW = 128, BW = 512, NCH = 2, FE = 2, CR = 4;

  logic          clk_i = 1'b0, reset_i = 1'b1;
  logic          csr_w_v_i = 1'b0;
  logic [3:0]    csr_addr_i = '0;
  logic [63:0]   csr_data_i = '0, csr_data_o;
  logic          blk_v_i = 1'b0;
  logic [0:0]    blk_ch_i = '0;
  logic [BW-1:0] blk_data_i = '0;
  logic          blk_ready_and_o;
  logic [PW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_v_o, wr_ready_and_i = 1'b0, wr_ack_v_i = 1'b0;
  logic          fence_v_i = 1'b0, fence_done_o, busy_o, panic_o;

  bp_be_accel_store_engine #(
    .paddr_width_p(PW), .data_width_p(DW), .block_width_p(BW),
    .num_ch_p(NCH), .fifo_els_p(FE), .credits_p(CR)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .csr_w_v_i(csr_w_v_i), .csr_addr_i(csr_addr_i), .csr_data_i(csr_data_i), .csr_data_o(csr_data_o),
    .blk_v_i(blk_v_i), .blk_ch_i(blk_ch_i), .blk_data_i(blk_data_i), .blk_ready_and_o(blk_ready_and_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_v_o(wr_v_o), .wr_ready_and_i(wr_ready_and_i),
    .wr_ack_v_i(wr_ack_v_i), .fence_v_i(fence_v_i), .fence_done_o(fence_done_o),
    .busy_o(busy_o), .panic_o(panic_o)
  );

  always #5 clk_i = ~clk_i;

  logic [PW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int total = 0, bad = 0, n_stores = 0, n_done = 0, pend_acks = 0;
  bit auto_ack = 1'b0;

  // Monitor: pops the scoreboard on every store handshake, sampled mid-cycle.
  always @(negedge clk_i) begin
    logic [PW-1:0] ea;
    logic [DW-1:0] ed;
    if (!reset_i && wr_v_o && wr_ready_and_i) begin
      n_stores++;
      if (auto_ack) pend_acks++;
      total++;
      if (exp_addr_q.size() == 0) begin
        bad++;
        $display("FAIL store_unexpected got addr=%h data=%h, required none", wr_addr_o, wr_data_o);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (wr_addr_o !== ea || wr_data_o !== ed) begin
          bad++;
          $display("FAIL store got addr=%h data=%h, required addr=%h data=%h", wr_addr_o, wr_data_o, ea, ed);
        end
      end
    end
    if (!reset_i && fence_done_o) n_done++;
  end

  // Ack driver: one ack per cycle while requests are pending.
  always @(posedge clk_i) begin
    #1;
    if (pend_acks > 0) begin
      wr_ack_v_i = 1'b1;
      pend_acks--;
    end else begin
      wr_ack_v_i = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [63:0] d);
    csr_w_v_i = 1'b1; csr_addr_i = a; csr_data_i = d;
    tick();
    csr_w_v_i = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [63:0] d);
    csr_addr_i = a;
    #1;
    d = csr_data_o;
  endtask

  task automatic add_ack(input int n);
    @(negedge clk_i);
    pend_acks += n;
  endtask

  task automatic send_blk(input logic ch, input logic [31:0] tag,
                          input logic [PW-1:0] a0, a1, a2, a3);
    logic [DW-1:0] beat;
    logic [PW-1:0] a [4];
    int g = 0;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int k = 0; k < 4; k++) begin
      beat = {tag, 32'(k), ~tag, 32'hC0DE_0000 + 32'(k)};
      blk_data_i[k*DW +: DW] = beat;
      exp_addr_q.push_back(a[k]);
      exp_data_q.push_back(beat);
    end
    blk_ch_i = ch;
    blk_v_i  = 1'b1;
    while (!blk_ready_and_o && g < 100) begin tick(); g++; end
    if (g >= 100) begin
      total++; bad++;
      $display("FAIL blk_accept_timeout got ready=0, required ready=1");
    end
    tick();
    blk_v_i = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int g = 0;
    while ((busy_o || exp_addr_q.size() != 0) && g < budget) begin tick(); g++; end
    total++;
    if (g >= budget) begin
      bad++;
      $display("FAIL %s_drain got busy=%0d pending=%0d, required idle", nm, busy_o, exp_addr_q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout, required completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    int s0, d0;

    tick(3);
    reset_i = 1'b0;
    chk("rst_wr_v", 64'(wr_v_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_panic", 64'(panic_o), 64'd0);
    chk("rst_fence_done", 64'(fence_done_o), 64'd0);
    csr_rd(4'd15, d); chk("rst_status", d, 64'd0);
    csr_rd(4'd0, d);  chk("rst_base0", d, 64'd0);

    // Single block, no wrap
    csr_wr(4'd0, 64'h1000);
    csr_rd(4'd3, d); chk("base_loads_ptr", d, 64'h1000);
    csr_wr(4'd1, 64'h1100);
    csr_wr(4'd2, 64'h10);
    csr_rd(4'd1, d); chk("limit_rd", d, 64'h1100);
    auto_ack = 1'b1; wr_ready_and_i = 1'b1;
    send_blk(1'b0, 32'hA1A1_0001, 40'h1000, 40'h1010, 40'h1020, 40'h1030);
    chk("first_beat_latency", 64'(wr_v_o), 64'd1);
    drain("blk1", 100);
    csr_rd(4'd3, d); chk("ptr_after_blk1", d, 64'h1040);

    // Wrap at limit, two blocks back to back
    csr_wr(4'd1, 64'h1020);
    csr_wr(4'd0, 64'h1000);
    send_blk(1'b0, 32'hB2B2_0002, 40'h1000, 40'h1010, 40'h1000, 40'h1010);
    send_blk(1'b0, 32'hB3B3_0003, 40'h1000, 40'h1010, 40'h1000, 40'h1010);
    drain("wrap", 100);
    csr_rd(4'd3, d); chk("ptr_after_wrap", d, 64'h1000);

    // Channel 1 window independent of channel 0
    csr_wr(4'd4, 64'h2000);
    csr_wr(4'd5, 64'h2040);
    csr_wr(4'd6, 64'h20);
    send_blk(1'b1, 32'hC4C4_0004, 40'h2000, 40'h2020, 40'h2000, 40'h2020);
    drain("ch1", 100);
    csr_rd(4'd3, d); chk("ch0_ptr_untouched", d, 64'h1000);
    csr_rd(4'd7, d); chk("ch1_ptr", d, 64'h2000);
    csr_wr(4'd8, 64'hDEAD);
    csr_rd(4'd8, d);  chk("unmapped_rd", d, 64'd0);
    csr_rd(4'd12, d); chk("perf_off_rd", d, 64'd0);

    // Credit saturation: no acks, two blocks queued
    auto_ack = 1'b0;
    s0 = n_stores;
    send_blk(1'b0, 32'hD5D5_0005, 40'h1000, 40'h1010, 40'h1000, 40'h1010);
    send_blk(1'b0, 32'hD6D6_0006, 40'h1000, 40'h1010, 40'h1000, 40'h1010);
    tick(15);
    chk("sat_store_cnt", 64'(n_stores - s0), 64'(CR));
    chk("sat_wr_v_low", 64'(wr_v_o), 64'd0);
    csr_rd(4'd15, d); chk("sat_status", d, 64'(CR));
    add_ack(1);
    tick(6);
    chk("sat_one_ack_store", 64'(n_stores - s0), 64'(CR + 1));
    auto_ack = 1'b1;
    add_ack(CR);
    drain("sat", 200);
    csr_rd(4'd15, d); chk("sat_status_drained", d, 64'd0);

    // Handshake and ack in the same cycle
    auto_ack = 1'b0; wr_ready_and_i = 1'b0;
    send_blk(1'b0, 32'hE7E7_0007, 40'h1000, 40'h1010, 40'h1000, 40'h1010);
    wr_ready_and_i = 1'b1;
    tick();
    wr_ready_and_i = 1'b0;
    csr_rd(4'd15, d); chk("one_store_credit", d, 64'd1);
    add_ack(1);
    tick();
    wr_ready_and_i = 1'b1;
    tick();
    wr_ready_and_i = 1'b0;
    csr_rd(4'd15, d); chk("hs_ack_same_cycle", d, 64'd1);
    add_ack(1);
    tick(3);
    csr_rd(4'd15, d); chk("hs_ack_cleared", d, 64'd0);
    auto_ack = 1'b1; wr_ready_and_i = 1'b1;
    drain("hsack", 100);

    // Fence with four outstanding stores, second fence merged
    auto_ack = 1'b0;
    send_blk(1'b0, 32'hF8F8_0008, 40'h1000, 40'h1010, 40'h1000, 40'h1010);
    tick(8);
    d0 = n_done;
    fence_v_i = 1'b1; tick(); fence_v_i = 1'b0;
    tick();
    fence_v_i = 1'b1; tick(); fence_v_i = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_i);
      if (c == 5 || c == 6 || c == 7 || c == 9) pend_acks++;
      if (c == 9) chk("fence_not_early", 64'(n_done - d0), 64'd0);
    end
    chk("fence_done_once", 64'(n_done - d0), 64'd1);
    tick();

    // Ack with nothing outstanding
    add_ack(1);
    tick();
    chk("panic_before", 64'(panic_o), 64'd0);
    tick();
    chk("panic_set", 64'(panic_o), 64'd1);
    tick(5);
    chk("panic_sticky", 64'(panic_o), 64'd1);
    csr_rd(4'd15, d); chk("panic_status", d, 64'h8);
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    chk("panic_reset", 64'(panic_o), 64'd0);
    csr_rd(4'd15, d); chk("status_reset", d, 64'd0);
    csr_rd(4'd0, d);  chk("base_reset", d, 64'd0);
    chk("sb_empty", 64'(exp_addr_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
